// File: rtl/x8_seven_segment_scan.sv
// rtl/x8_seven_segment_scan.sv - 8-digit multiplexed seven-segment scanner with PWM dimming
// and frame-synchronous double-buffered display updates.
module x8_seven_segment_scan #(
  parameter int TICK = 6250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [55:0] segs_in,
  input  logic        load,
  input  logic        enable,
  input  logic [2:0]  brightness,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done,
  output logic        pending
);

  localparam logic [15:0] TICK_LAST = 16'(TICK - 1);

  logic [15:0] tick_q, tick_d;
  logic [2:0]  sub_q, sub_d;
  logic [2:0]  dig_q, dig_d;
  logic [55:0] disp_q, disp_d;
  logic [55:0] pend_reg_q, pend_reg_d;
  logic        pend_q, pend_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        fd_q, fd_d;

  logic        tick_wrap;
  logic        sub_wrap;
  logic        boundary;
  logic        lit;
  logic [6:0]  cur_seg;

  always_comb begin
    tick_wrap = (tick_q == TICK_LAST);
    sub_wrap  = tick_wrap && (sub_q == 3'd7);
    boundary  = enable && sub_wrap && (dig_q == 3'd7);
    lit       = enable && (sub_q <= brightness);

    cur_seg = 7'h7F;
    for (int k = 0; k < 8; k++) begin
      if (dig_q == 3'(k)) cur_seg = disp_q[7*k +: 7];
    end

    // Disabled scanning parks every counter at zero so re-enable restarts at digit 0.
    tick_d = 16'd0;
    sub_d  = 3'd0;
    dig_d  = 3'd0;
    if (enable) begin
      tick_d = tick_wrap ? 16'd0 : tick_q + 16'd1;
      sub_d  = tick_wrap ? sub_q + 3'd1 : sub_q;
      dig_d  = sub_wrap ? dig_q + 3'd1 : dig_q;
    end

    an_d  = lit ? ~(8'b1 << dig_q) : 8'hFF;
    seg_d = lit ? cur_seg : 7'h7F;
    fd_d  = boundary;

    disp_d     = disp_q;
    pend_reg_d = pend_reg_q;
    pend_d     = pend_q;
    if (boundary) begin
      if (load) begin
        disp_d     = segs_in;
        pend_reg_d = segs_in;
        pend_d     = 1'b0;
      end else if (pend_q) begin
        disp_d = pend_reg_q;
        pend_d = 1'b0;
      end
    end else if (load) begin
      pend_reg_d = segs_in;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q     <= 16'd0;
      sub_q      <= 3'd0;
      dig_q      <= 3'd0;
      disp_q     <= '1;
      pend_reg_q <= '1;
      pend_q     <= 1'b0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
      fd_q       <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      sub_q      <= sub_d;
      dig_q      <= dig_d;
      disp_q     <= disp_d;
      pend_reg_q <= pend_reg_d;
      pend_q     <= pend_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      fd_q       <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_x8_seven_segment_scan.sv
// tb/tb_x8_seven_segment_scan.sv - scoreboard bench for x8_seven_segment_scan at TICK=2.
module tb_x8_seven_segment_scan;

  localparam int TICK = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [55:0] segs_in;
  logic        load;
  logic        enable;
  logic [2:0]  brightness;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame_done;
  logic        pending;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  logic [55:0] v_one, v_a, v_b, v_c, v_d, v_e, v_blank;

  x8_seven_segment_scan #(.TICK(TICK)) dut (
    .clk(clk), .rst_n(rst_n), .segs_in(segs_in), .load(load), .enable(enable),
    .brightness(brightness), .an(an), .seg(seg), .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_load(input logic [55:0] v);
    segs_in = v;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 400);
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL wait_frame_done got=%b exp=1", frame_done);
    end
  endtask

  // Starts at a negedge where frame_done is high; checks the following 128 samples.
  task automatic check_frame(input logic [2:0] br, input logic [55:0] disp, input string tag);
    logic [15:0] got, e;
    for (int i = 0; i < 64 * TICK; i++) begin
      int d  = i / (8 * TICK);
      int sp = (i % (8 * TICK)) / TICK;
      logic is_lit = (sp <= int'(br));
      logic [7:0] ea = is_lit ? ~(8'b1 << d) : 8'hFF;
      logic [6:0] es = is_lit ? disp[7*d +: 7] : 7'h7F;
      exp_q.push_back({ea, es, (i == 64 * TICK - 1)});
    end
    for (int i = 0; i < 64 * TICK; i++) begin
      @(negedge clk);
      got = {an, seg, frame_done};
      e   = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s[%0d] an/seg/fd got=%h exp=%h", tag, i, got, e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; enable = 1'b1; brightness = 3'd7; segs_in = '0;
    repeat (3) @(negedge clk);
    total++; if (an !== 8'hFF) begin bad++; $display("FAIL reset_an got=%h exp=ff", an); end
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", pending); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
  endtask

  task automatic test_load_and_scan();
    rst_n = 1'b1;
    do_load(v_one);
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL load_pending got=%b exp=1", pending); end
    wait_fd();
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL boundary_pending got=%b exp=0", pending); end
    check_frame(3'd7, v_one, "scan_full");
  endtask

  task automatic test_brightness0();
    brightness = 3'd0;
    check_frame(3'd0, v_one, "scan_dim");
  endtask

  task automatic test_back_to_back();
    brightness = 3'd7;
    do_load(v_a);
    repeat (3) @(negedge clk);
    do_load(v_b);
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL b2b_pending got=%b exp=1", pending); end
    wait_fd();
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL b2b_cleared got=%b exp=0", pending); end
    check_frame(3'd7, v_b, "latest_wins");
  endtask

  task automatic test_load_on_boundary();
    repeat (64 * TICK - 1) @(negedge clk);
    do_load(v_c);
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL bnd_fd got=%b exp=1", frame_done); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL bnd_pending got=%b exp=0", pending); end
    check_frame(3'd7, v_c, "boundary_load");
  endtask

  task automatic test_enable_drop();
    repeat (3 * 8 * TICK + 2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    total++; if (an !== 8'hFF) begin bad++; $display("FAIL dis_an got=%h exp=ff", an); end
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL dis_seg got=%h exp=7f", seg); end
    do_load(v_d);
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL dis_pending got=%b exp=1", pending); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (frame_done !== 1'b0 || an !== 8'hFF) begin
        bad++; $display("FAIL dis_hold[%0d] fd/an got=%b/%h exp=0/ff", i, frame_done, an);
      end
    end
    enable = 1'b1;
    check_frame(3'd7, v_c, "reenable");
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL reen_pending got=%b exp=0", pending); end
    check_frame(3'd7, v_d, "deferred");
  endtask

  task automatic test_reset_mid_frame();
    repeat (20) @(negedge clk);
    do_load(v_e);
    total++; if (pending !== 1'b1) begin bad++; $display("FAIL mid_pending got=%b exp=1", pending); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (an !== 8'hFF) begin bad++; $display("FAIL mid_rst_an got=%h exp=ff", an); end
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL mid_rst_seg got=%h exp=7f", seg); end
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL mid_rst_pending got=%b exp=0", pending); end
    @(negedge clk);
    rst_n = 1'b1;
    check_frame(3'd7, v_blank, "post_reset");
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL post_rst_pending got=%b exp=0", pending); end
  endtask

  initial begin
    v_one   = {8{7'b0000001}};
    v_a     = {8{7'h2A}};
    v_blank = '1;
    v_e     = 56'h0123456789ABCD;
    for (int k = 0; k < 8; k++) begin
      v_b[7*k +: 7] = 7'(k * 9 + 3);
      v_c[7*k +: 7] = 7'(k * 13 + 5);
      v_d[7*k +: 7] = 7'(8'h40 | k);
    end
    test_reset();
    test_load_and_scan();
    test_brightness0();
    test_back_to_back();
    test_load_on_boundary();
    test_enable_drop();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
